// File: rtl/uart_rx_oversample.sv
// 8N1-style UART receiver with its own oversample tick derived from baud_div.
// It has a 2-FF rx synchronizer, mid-bit sampling, and one-cycle valid/error strobes.
module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 27
) (
  input  logic                 clock_in,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [DIV_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                 tick;
  logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d      = rx;
    sync2_d      = sync1_q;
    tick         = (tcnt_q >= baud_div);
    tcnt_d       = tick ? '0 : tcnt_q + DIV_WIDTH'(1);
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d      = ST_START;
            sample_cnt_d = '0;
          end
        end
        ST_START: begin
          // Half a bit in: confirm the start bit is still low, else treat it as a glitch.
          if (sample_cnt_q == HALF_LAST) begin
            sample_cnt_d = '0;
            bit_idx_d    = '0;
            state_d      = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (sample_cnt_q == FULL_LAST) begin
            sample_cnt_d = '0;
            shift_d      = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_idx_d    = bit_idx_q + BIT_W'(1);
            if (bit_idx_q == BIT_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop lets a following start edge half a bit later be caught.
          if (sample_cnt_q == FULL_LAST) begin
            sample_cnt_d = '0;
            state_d      = ST_IDLE;
            if (rx_s) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      tcnt_q       <= '0;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tcnt_q       <= tcnt_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed testbench for uart_rx_oversample: per-scenario tasks with inline checks.
module tb_uart_rx_oversample;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_WIDTH  = 27;

  logic                 clock_in = 1'b0;
  logic                 rst      = 1'b1;
  logic [DIV_WIDTH-1:0] baud_div = 27'd4;
  logic                 rx       = 1'b1;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int wide_cnt = 0;
  int both_cnt = 0;
  int last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_oversample #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .clock_in (clock_in),
    .rst      (rst),
    .baud_div (baud_div),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cyc <= cyc + 1;

  always @(negedge clock_in) begin
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      got_q.push_back(rx_data);
      last_valid_cyc = cyc;
    end
    if (frame_err === 1'b1) err_cnt++;
    if ((rx_valid === 1'b1 && prev_valid === 1'b1) || (frame_err === 1'b1 && prev_err === 1'b1)) wide_cnt++;
    if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    prev_valid = rx_valid;
    prev_err   = frame_err;
  end

  task automatic drive_bits(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop);
    drive_bits(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bits(b[i], bc);
    drive_bits(stop, bc);
  endtask

  task automatic test_reset;
    rx = 1'b1;
    baud_div = 27'd4;
    #2 rst = 1'b0;
    repeat (3) @(posedge clock_in);
    #1;
    total_cnt++;
    if (rx_data !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", rx_data); else pass_cnt++;
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); else pass_cnt++;
    total_cnt++;
    if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", frame_err); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    rst = 1'b1;
    drive_bits(1'b1, 20);
    total_cnt++;
    if (busy !== 1'b0 || rx_data !== 8'h00) $display("FAIL post_reset_idle busy=%b rx_data=%h exp busy=0 rx_data=00", busy, rx_data); else pass_cnt++;
  endtask

  task automatic test_basic;
    int v0, e0, base, t0, lat;
    baud_div = 27'd4;
    drive_bits(1'b1, 160);
    v0 = valid_cnt; e0 = err_cnt; base = got_q.size();
    t0 = cyc;
    send_frame(8'hA5, 80, 1'b1);
    drive_bits(1'b1, 160);
    lat = last_valid_cyc - t0;
    total_cnt++;
    if (valid_cnt - v0 !== 1) $display("FAIL basic_valid_count got=%0d exp=1", valid_cnt - v0); else pass_cnt++;
    total_cnt++;
    if (got_q.size() <= base || got_q[base] !== 8'hA5) $display("FAIL basic_data got=%h exp=a5", (got_q.size() > base) ? got_q[base] : 8'hxx); else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'hA5) $display("FAIL basic_rx_data_held got=%h exp=a5", rx_data); else pass_cnt++;
    total_cnt++;
    if (err_cnt - e0 !== 0) $display("FAIL basic_frame_err got=%0d exp=0", err_cnt - e0); else pass_cnt++;
    total_cnt++;
    if (lat < 752 || lat > 768) $display("FAIL basic_latency got=%0d exp=752..768", lat); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int v0, e0, base;
    baud_div = 27'd0;
    drive_bits(1'b1, 48);
    v0 = valid_cnt; e0 = err_cnt; base = got_q.size();
    send_frame(8'h00, 16, 1'b1);
    send_frame(8'hFF, 16, 1'b1);
    drive_bits(1'b1, 32);
    total_cnt++;
    if (valid_cnt - v0 !== 2) $display("FAIL b2b_valid_count got=%0d exp=2", valid_cnt - v0); else pass_cnt++;
    total_cnt++;
    if (got_q.size() < base + 2 || got_q[base] !== 8'h00) $display("FAIL b2b_first got=%h exp=00", (got_q.size() > base) ? got_q[base] : 8'hxx); else pass_cnt++;
    total_cnt++;
    if (got_q.size() < base + 2 || got_q[base+1] !== 8'hFF) $display("FAIL b2b_second got=%h exp=ff", (got_q.size() > base + 1) ? got_q[base+1] : 8'hxx); else pass_cnt++;
    total_cnt++;
    if (err_cnt - e0 !== 0) $display("FAIL b2b_frame_err got=%0d exp=0", err_cnt - e0); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int v0, e0;
    logic saw_busy;
    baud_div = 27'd4;
    drive_bits(1'b1, 160);
    v0 = valid_cnt; e0 = err_cnt;
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 15) rx = 1'b1;
      @(posedge clock_in);
      #1;
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    total_cnt++;
    if (saw_busy !== 1'b1) $display("FAIL glitch_busy_rise got=%b exp=1", saw_busy); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL glitch_busy_fall got=%b exp=0", busy); else pass_cnt++;
    total_cnt++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) $display("FAIL glitch_pulses valid=%0d err=%0d exp 0/0", valid_cnt - v0, err_cnt - e0); else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'hFF) $display("FAIL glitch_rx_data got=%h exp=ff", rx_data); else pass_cnt++;
  endtask

  task automatic test_frame_err;
    int v0, e0;
    baud_div = 27'd4;
    drive_bits(1'b1, 160);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h3C, 80, 1'b0);
    drive_bits(1'b1, 240);
    total_cnt++;
    if (err_cnt - e0 !== 1) $display("FAIL ferr_count got=%0d exp=1", err_cnt - e0); else pass_cnt++;
    total_cnt++;
    if (valid_cnt - v0 !== 0) $display("FAIL ferr_valid got=%0d exp=0", valid_cnt - v0); else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'hFF) $display("FAIL ferr_rx_data got=%h exp=ff", rx_data); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL ferr_idle_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame;
    int v0, e0, base;
    baud_div = 27'd4;
    drive_bits(1'b1, 160);
    v0 = valid_cnt; e0 = err_cnt; base = got_q.size();
    // Aborted frame is 0xF0: line stays high from bit 4 onward, so no false edge follows.
    drive_bits(1'b0, 80 * 5);
    drive_bits(1'b1, 10);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL rstmid_busy_before got=%b exp=1", busy); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid_outputs rx_data=%h valid=%b err=%b busy=%b exp 00/0/0/0", rx_data, rx_valid, frame_err, busy);
    else pass_cnt++;
    repeat (3) @(posedge clock_in);
    #1;
    total_cnt++;
    if (rx_data !== 8'h00 || busy !== 1'b0) $display("FAIL rstmid_held rx_data=%h busy=%b exp 00/0", rx_data, busy); else pass_cnt++;
    rst = 1'b1;
    drive_bits(1'b1, 66 + 80 * 4 + 160);
    total_cnt++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) $display("FAIL rstmid_no_pulse valid=%0d err=%0d exp 0/0", valid_cnt - v0, err_cnt - e0); else pass_cnt++;
    send_frame(8'h81, 80, 1'b1);
    drive_bits(1'b1, 160);
    total_cnt++;
    if (valid_cnt - v0 !== 1) $display("FAIL rstmid_valid_count got=%0d exp=1", valid_cnt - v0); else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h81 || got_q.size() <= base || got_q[base] !== 8'h81) $display("FAIL rstmid_data got=%h exp=81", rx_data); else pass_cnt++;
  endtask

  task automatic test_random;
    int bds[2];
    int nbytes[2];
    int v0, base, bc;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    bds[0] = 2; bds[1] = 7;
    nbytes[0] = 80; nbytes[1] = 25;
    for (int k = 0; k < 2; k++) begin
      baud_div = DIV_WIDTH'(bds[k]);
      bc = (bds[k] + 1) * OVERSAMPLE;
      drive_bits(1'b1, 3 * bc);
      v0 = valid_cnt; base = got_q.size();
      exp_q.delete();
      for (int n = 0; n < nbytes[k]; n++) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        send_frame(b, bc, 1'b1);
      end
      drive_bits(1'b1, 2 * bc);
      total_cnt++;
      if (valid_cnt - v0 !== nbytes[k]) $display("FAIL rand_count_bd%0d got=%0d exp=%0d", bds[k], valid_cnt - v0, nbytes[k]); else pass_cnt++;
      for (int n = 0; n < nbytes[k]; n++) begin
        total_cnt++;
        if (base + n >= got_q.size()) $display("FAIL rand_byte_bd%0d_%0d got=none exp=%h", bds[k], n, exp_q[n]);
        else if (got_q[base+n] !== exp_q[n]) $display("FAIL rand_byte_bd%0d_%0d got=%h exp=%h", bds[k], n, got_q[base+n], exp_q[n]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (wide_cnt !== 0) $display("FAIL pulse_width wide_pulses=%0d exp=0", wide_cnt); else pass_cnt++;
    total_cnt++;
    if (both_cnt !== 0) $display("FAIL pulse_overlap both=%0d exp=0", both_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- 8N1-style UART receiver; the receive-side counterpart of the team's baud-rate divider and transmit path.
- Generates its own oversample tick from the same `baud_div` value the transmit side uses, so both ends share one divisor register.
- Includes a 2-FF input synchronizer, a start/data/stop FSM with mid-bit sampling, and a one-cycle `rx_valid` strobe into the processor's UART register block.

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first.
- OVERSAMPLE, 16, ticks per bit; must be even and >= 4.
- DIV_WIDTH, 27, width of `baud_div`.

Ports:
- clock_in  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset; all state is cleared while low.
- baud_div  input  DIV_WIDTH  tick divisor; tick period = baud_div+1 clock_in cycles.
- rx  input  1  serial line, idle high, asynchronous to clock_in.
- rx_data  output  DATA_BITS  last good frame payload; held until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE. Internal state is also cleared: tick counter=0, sample_cnt=0, bit_idx=0, shift register=0, and both synchronizer flops=1.
- Synchronizer: rx passes through 2 flops; only the second flop output (rx_s) is used by the FSM.
- Tick generator: `tcnt` counts up every cycle. When tcnt >= baud_div, tcnt<=0 and `tick`=1 for that cycle; otherwise tick=0.
  - baud_div=0 gives a tick every cycle.
  - A baud_div change takes effect at the next compare. Behaviour during a frame in which baud_div changes is not defined.
- FSM transitions, evaluated only on tick cycles unless stated otherwise:
  - IDLE: if rx_s==0, go to START with sample_cnt=0.
  - START: sample_cnt++. At sample_cnt==OVERSAMPLE/2-1:
    - if rx_s==0, go to DATA with sample_cnt=0, bit_idx=0;
    - else false start: go to IDLE with no outputs.
  - DATA: sample_cnt++. At sample_cnt==OVERSAMPLE-1, shift in rx_s, set sample_cnt=0 and bit_idx++.
    - Shift right with new bit at MSB, so the first bit received lands at bit 0.
    - After bit DATA_BITS-1 is captured, go to STOP.
  - STOP: sample_cnt++. At sample_cnt==OVERSAMPLE-1, go to IDLE and:
    - if rx_s==1: rx_data<=shift and rx_valid pulses;
    - if rx_s==0: frame_err pulses, rx_data is unchanged, rx_valid=0.
- Pulses: rx_valid and frame_err are high for exactly one clock_in cycle and are never high together.
- Back-to-back frames: the FSM returns to IDLE at mid-stop, so a start edge arriving one half-bit later is caught without loss.
- Break condition (rx held low): each frame yields frame_err. The FSM re-enters START immediately after each error and keeps doing so while rx stays low. No rx_valid pulses occur.
- Reset mid-frame: the partial frame is discarded and no pulse is emitted. After release, reception starts at the next falling edge of rx_s.
- Overrun: there is no handshake. A new good frame overwrites rx_data; the consumer must read it within one frame time.
- Latency: rx_valid asserts ~(1.5+DATA_BITS)*OVERSAMPLE ticks after the start edge, plus at most 2+(baud_div+1) cycles for sync and tick alignment.

Test Plan:
- baud_div=4 (bit = 80 cycles), send 0xA5 with a good stop bit → single rx_valid pulse, rx_data=0xA5, frame_err=0. Pulse arrives 9.5 bits (760 cycles) ±8 cycles after the start edge.
- baud_div=0, send 0x00 then 0xFF back-to-back with a 1-bit stop and no extra idle → two rx_valid pulses with rx_data 0x00 then 0xFF, and no frame_err.
- baud_div=4, low glitch of 3 bit-tick lengths (15 cycles) on idle rx → busy rises then falls within 8 ticks; no rx_valid, no frame_err; rx_data unchanged.
- baud_div=4, send 0x3C with stop bit forced 0 → frame_err pulses once, rx_valid stays 0, rx_data keeps its prior value.
- Assert rst low at bit 4 of a frame for 3 cycles, then send 0x81 → all outputs 0 during reset. Afterwards, no pulse for the aborted frame, then rx_valid with rx_data=0x81.
- baud_div=2 versus baud_div=7 with the matching bit periods, random bytes (≥100) → every byte received correctly, rx_valid count equals bytes sent, and no two-cycle-wide pulses.
